// File: rtl/t07_ssdec_pkg.sv
// Shared constants and types for the seven-segment serial link.
// Used by the receiver here and kept in step with the transmitter side.
package t07_ssdec_pkg;

  // Bits per segment digit.
  localparam int unsigned SEG_BITS        = 8;
  // Default link geometry, shared with the transmitter.
  localparam int unsigned DEF_NUM_DIGITS  = 8;
  localparam int unsigned DEF_IDLE_CYCLES = 256;

  // Receiver frame state.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  // Number of serial bits in one frame for a given digit count.
  function automatic int unsigned frame_bits(input int unsigned num_digits);
    return num_digits * SEG_BITS;
  endfunction

endpackage

// File: rtl/t07_sync_edge.sv
// Two-flop synchroniser with rising-edge detect on an asynchronous strobe,
// plus an equal-depth synchroniser for companion data sampled with it.
// Ports:
//   clk, nrst  : system clock, asynchronous active-low reset
//   async_in   : asynchronous strobe (serial clock)
//   data_in    : asynchronous data that travels alongside the strobe
//   rise_c     : combinational; high for one clk when the synced strobe rises
//   data_sync  : data after the same two-flop delay as the strobe
module t07_sync_edge #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              async_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              rise_c,
  output logic [DATA_W-1:0] data_sync
);

  logic              s1_q;
  logic              s2_q;
  logic              prev_q;
  logic [DATA_W-1:0] d1_q;
  logic [DATA_W-1:0] d2_q;

  // Synchroniser chains; prev_q remembers the last synced strobe level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      d1_q   <= '0;
      d2_q   <= '0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      d1_q   <= data_in;
      d2_q   <= d1_q;
    end
  end

  assign rise_c    = s2_q & ~prev_q;
  assign data_sync = d2_q;

endmodule

// File: rtl/t07_ssdec_receiver.sv
// Serial-to-parallel receiver for the seven-segment link. Oversamples
// ssdec_sck/ssdec_sdi in the clk domain, assembles NUM_DIGITS*8-bit frames
// (MSB first) and latches them onto seg_out. An sck idle timeout ends a
// partial frame, which is discarded and flagged on frame_err.
// Ports:
//   clk, nrst    : system clock, asynchronous active-low reset
//   ssdec_sck    : serial clock, asynchronous to clk
//   ssdec_sdi    : serial data, valid at sck rising edge
//   seg_out      : latched segment bytes, digit d = seg_out[8d+7:8d]
//   frame_valid  : one-cycle pulse when seg_out updates
//   frame_err    : one-cycle pulse when a partial frame is discarded
//   busy         : high while a frame is in progress
module t07_ssdec_receiver
  import t07_ssdec_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           ssdec_sck,
  input  logic                           ssdec_sdi,
  output logic [NUM_DIGITS*SEG_BITS-1:0] seg_out,
  output logic                           frame_valid,
  output logic                           frame_err,
  output logic                           busy
);

  localparam int unsigned FRAME_BITS = NUM_DIGITS * SEG_BITS;
  localparam int unsigned BCW        = $clog2(FRAME_BITS + 1);
  localparam int unsigned ICW        = $clog2(IDLE_CYCLES);

  logic rise;
  logic sdi_s2;

  rx_state_t             state_q,    state_d;
  logic [BCW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [ICW-1:0]        idle_cnt_q, idle_cnt_d;
  // The oldest bit leaves the window on commit, so only FRAME_BITS-1 are kept.
  logic [FRAME_BITS-2:0] shift_q,    shift_d;
  logic [FRAME_BITS-1:0] seg_q,      seg_d;
  logic                  valid_q,    valid_d;
  logic                  err_q,      err_d;
  logic                  busy_q;

  // sck drives the edge detector; sdi rides the same sync depth.
  t07_sync_edge #(
    .DATA_W (1)
  ) u_sck_sync (
    .clk       (clk),
    .nrst      (nrst),
    .async_in  (ssdec_sck),
    .data_in   (ssdec_sdi),
    .rise_c    (rise),
    .data_sync (sdi_s2)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    seg_d      = seg_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (rise) begin
          shift_d   = {shift_q[FRAME_BITS-3:0], sdi_s2};
          bit_cnt_d = BCW'(1);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (rise) begin
          idle_cnt_d = '0;
          shift_d    = {shift_q[FRAME_BITS-3:0], sdi_s2};
          if (bit_cnt_q == BCW'(FRAME_BITS - 1)) begin
            // Last bit of the frame: commit straight from the window.
            seg_d     = {shift_q, sdi_s2};
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else if (idle_cnt_q == ICW'(IDLE_CYCLES - 1)) begin
          err_d      = 1'b1;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + ICW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      seg_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      seg_q      <= seg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= (state_d == SHIFT);
    end
  end

  assign seg_out     = seg_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_t07_ssdec_receiver.sv
// Bench for t07_ssdec_receiver: a frame-level reference model tracks the
// detected sck rises and predicts every output on every cycle; directed
// sequences pin literal results.
module tb_t07_ssdec_receiver;

  localparam int unsigned ND = 8;
  localparam int unsigned IC = 256;
  localparam int unsigned FB = ND * 8;
  localparam logic [63:0] FRAME1 = 64'h3F06_5B4F_666D_7D07;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          ssdec_sck = 1'b0;
  logic          ssdec_sdi = 1'b0;
  logic [FB-1:0] seg_out;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int n_valid = 0;
  int n_err   = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int last_err_cyc   = 0;
  int last_rise_cyc  = 0;
  logic [FB-1:0] valid_seg = '0;
  logic          valid_busy = 1'b0;

  // Reference model state.
  logic [2:0]    sck_h, sdi_h;
  logic [FB-1:0] m_acc;
  int            m_nb, m_since;
  logic [FB-1:0] exp_seg;
  logic          exp_valid, exp_err, exp_busy;

  t07_ssdec_receiver #(
    .NUM_DIGITS  (ND),
    .IDLE_CYCLES (IC)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .ssdec_sck   (ssdec_sck),
    .ssdec_sdi   (ssdec_sdi),
    .seg_out     (seg_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a raw sck rise seen at edge k is acted on at edge k+2 (three edges
  // after the pin changed); bits collect until a full frame or an idle timeout.
  always @(posedge clk or negedge nrst) begin : model
    logic [FB-1:0] a;
    int            n, s;
    logic          v, e;
    if (!nrst) begin
      sck_h     <= '0;
      sdi_h     <= '0;
      m_acc     <= '0;
      m_nb      <= 0;
      m_since   <= 0;
      exp_seg   <= '0;
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
      exp_busy  <= 1'b0;
    end else begin
      a = m_acc;
      n = m_nb;
      s = m_since;
      v = 1'b0;
      e = 1'b0;
      if (sck_h[1] && !sck_h[2]) begin
        a = {a[FB-2:0], sdi_h[1]};
        n = n + 1;
        s = 0;
        if (n == FB) begin
          v = 1'b1;
          n = 0;
          exp_seg <= a;
        end
      end else if (n > 0) begin
        s = s + 1;
        if (s == IC) begin
          e = 1'b1;
          n = 0;
        end
      end
      sck_h     <= {sck_h[1:0], ssdec_sck};
      sdi_h     <= {sdi_h[1:0], ssdec_sdi};
      m_acc     <= a;
      m_nb      <= n;
      m_since   <= s;
      exp_valid <= v;
      exp_err   <= e;
      exp_busy  <= (n > 0);
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (nrst) begin
      checks = checks + 1;
      if (frame_valid !== exp_valid || frame_err !== exp_err ||
          busy !== exp_busy || seg_out !== exp_seg) begin
        failures = failures + 1;
        $display("FAIL cycle_model cyc=%0d actual v=%b e=%b b=%b seg=%h required v=%b e=%b b=%b seg=%h",
                 cyc, frame_valid, frame_err, busy, seg_out,
                 exp_valid, exp_err, exp_busy, exp_seg);
      end
      if (frame_valid) begin
        n_valid        = n_valid + 1;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        valid_seg      = seg_out;
        valid_busy     = busy;
      end
      if (frame_err) begin
        n_err        = n_err + 1;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sck period of 2*half clk; sdi is scrambled once the rise has been sampled.
  task automatic send_bit(input logic b, input int half);
    @(posedge clk);
    #1 ssdec_sck = 1'b0;
    ssdec_sdi = b;
    repeat (half) @(posedge clk);
    #1 ssdec_sck = 1'b1;
    last_rise_cyc = cyc;
    for (int j = 0; j < half - 1; j++) begin
      @(posedge clk);
      if (j == 0) begin
        #1 ssdec_sdi = 1'($urandom);
      end
    end
  endtask

  task automatic send_bits(input logic [127:0] data, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[i], half);
  endtask

  initial begin : stim
    int v0, e0;
    logic [127:0] rd;
    int len, half;

    // Reset and long idle.
    idle(3);
    nrst = 1'b1;
    idle(1000);
    chk("idle_seg", 64'(seg_out), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_pulses", 64'(n_valid + n_err), 64'h0);

    // Single full frame at sck period 8.
    v0 = n_valid;
    send_bits({64'h0, FRAME1}, 64, 4);
    idle(8);
    chk("frame1_count", 64'(n_valid - v0), 64'd1);
    chk("frame1_seg", 64'(valid_seg), FRAME1);
    chk("frame1_busy_at_valid", 64'(valid_busy), 64'h0);

    // Partial frame then timeout.
    e0 = n_err;
    send_bits({64'h0, 64'hABCD_E000_0000_0000}, 20, 4);
    idle(IC + 40);
    chk("timeout_count", 64'(n_err - e0), 64'd1);
    chk("timeout_latency", 64'(last_err_cyc - last_rise_cyc), 64'(IC + 3));
    chk("timeout_seg_kept", 64'(seg_out), FRAME1);

    // Back-to-back frames, no gap.
    v0 = n_valid;
    send_bits({64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 128, 4);
    idle(8);
    chk("b2b_count", 64'(n_valid - v0), 64'd2);
    chk("b2b_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'(64 * 8));
    chk("b2b_seg", 64'(seg_out), 64'h0);

    // Over-length stream: 64 + 6 bits.
    v0 = n_valid;
    e0 = n_err;
    send_bits({58'h0, 64'hA5A5_0F0F_1234_5678, 6'b101010}, 70, 4);
    idle(IC + 40);
    chk("over_valid_count", 64'(n_valid - v0), 64'd1);
    chk("over_seg", 64'(valid_seg), 64'hA5A5_0F0F_1234_5678);
    chk("over_err_count", 64'(n_err - e0), 64'd1);

    // Asynchronous reset mid-frame, then a clean frame.
    e0 = n_err;
    send_bits({64'h0, 64'h1357_9BDF_0000_0000}, 30, 4);
    #3 nrst = 1'b0;
    #1;
    chk("rst_seg", 64'(seg_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    ssdec_sck = 1'b0;
    ssdec_sdi = 1'b0;
    idle(2);
    nrst = 1'b1;
    v0 = n_valid;
    send_bits({64'h0, 64'hDEAD_BEEF_CAFE_F00D}, 64, 4);
    idle(8);
    chk("rst_frame_count", 64'(n_valid - v0), 64'd1);
    chk("rst_frame_seg", 64'(seg_out), 64'hDEAD_BEEF_CAFE_F00D);
    chk("rst_no_err", 64'(n_err - e0), 64'd0);

    // Randomised streams at assorted sck rates; the model checks every cycle.
    for (int t = 0; t < 14; t++) begin
      rd   = {$urandom, $urandom, $urandom, $urandom};
      len  = $urandom_range(1, 80);
      half = $urandom_range(1, 4);
      send_bits(rd, len, half);
      if ($urandom_range(0, 1) == 1) idle(IC + 10);
    end
    idle(IC + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
